jtpopeye_colmix_n: RTL and testbench

Parametrised colour mixer for the video output stage. Takes N tile/sprite layers, each with a colour index and a transparency flag. Resolves priority, looks up a programmable palette RAM and applies blanking and a frame-synchronous global fade, producing RGB at the DAC. It is the multi-layer successor of the fixed three-layer PROM mixer, with a runtime-loadable palette and brightness control.

---
 rtl/jtpopeye_colmix_n.sv | 236 +++++++++++++++++++++++
 tb/tb_jtpopeye_colmix_n.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_colmix_n.sv
`default_nettype none
// ============================================================================
// Module   : jtpopeye_colmix_n
// Purpose  : Multi-layer colour mixer. Picks the highest-priority opaque
//            layer and looks up its colour in a runtime-loadable palette RAM.
//            It then applies blanking and a frame-synchronous global fade, and
//            registers RGB for the DAC.
// Ports    : clk, rst (sync, active-high), cen (pixel enable)
//            prog_addr/prog_din/prog_we : palette write port (any clk)
//            lay_col/lay_v              : per-layer colour index / opaque flag
//            HB_n/VB_n                  : active-low blanking
//            fade_out/fade_in/fade_busy : global brightness ramp control
//            red/green/blue             : registered colour output
// Revision : 1.0 - initial release
// ============================================================================
module jtpopeye_colmix_n #(
    parameter int NL    = 3,
    parameter int IW    = 5,
    parameter int CW    = 3,
    parameter int FSTEP = 4,
    localparam int LSW  = (NL <= 2) ? 1 : $clog2(NL)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cen,
    input  logic [LSW+IW-1:0]   prog_addr,
    input  logic [3*CW-1:0]     prog_din,
    input  logic                prog_we,
    input  logic [NL*IW-1:0]    lay_col,
    input  logic [NL-1:0]       lay_v,
    input  logic                HB_n,
    input  logic                VB_n,
    input  logic                fade_out,
    input  logic                fade_in,
    output logic                fade_busy,
    output logic [CW-1:0]       red,
    output logic [CW-1:0]       green,
    output logic [CW-1:0]       blue
);

    localparam int c_AW = LSW + IW;
    localparam int c_PD = 1 << c_AW;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_OUT   = 2'd1;
    localparam logic [1:0] c_ST_BLACK = 2'd2;
    localparam logic [1:0] c_ST_IN    = 2'd3;

    localparam logic [3:0] c_FLAST = 4'(FSTEP - 1);

    // ------------------------------------------------------------------
    // Priority resolve. The background layer is treated as always opaque,
    // so it is the fallback when no higher layer claims the pixel.
    // ------------------------------------------------------------------
    logic [LSW-1:0] w_sel;
    logic [IW-1:0]  w_col;

    always_comb begin
        w_sel = LSW'(NL - 1);
        w_col = lay_col[(NL-1)*IW +: IW];
        for (int k = NL - 1; k >= 0; k--) begin
            if (lay_v[k] || (k == NL - 1)) begin
                w_sel = LSW'(k);
                w_col = lay_col[k*IW +: IW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Palette RAM: no reset. The read is non-blocking, so a same-clk write
    // to the address being read yields the old contents.
    // ------------------------------------------------------------------
    logic [3*CW-1:0] pal_mem [0:c_PD-1];
    logic [3*CW-1:0] pal_rd_q;
    logic [c_AW-1:0] addr_q, addr_d;

    always_ff @(posedge clk) begin
        if (prog_we)
            pal_mem[prog_addr] <= prog_din;
        if (cen)
            pal_rd_q <= pal_mem[addr_q];
    end

    // ------------------------------------------------------------------
    // Pipeline and fade state
    // ------------------------------------------------------------------
    logic          blank1_q, blank1_d;
    logic          blank2_q, blank2_d;
    logic [CW-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bright_q, bright_d;
    logic [3:0]    fcnt_q, fcnt_d;
    logic          vb_hist_q, vb_hist_d;
    logic          pend_out_q, pend_out_d;
    logic          pend_in_q, pend_in_d;

    logic            w_req_out, w_req_in, w_tick, w_step;
    logic [CW+2:0]   w_bmul, w_pr, w_pg, w_pb;

    // Brightness scale: c*(bright+1)>>3, so bright=7 is the identity.
    always_comb begin
        w_bmul = (CW+3)'({1'b0, bright_q}) + (CW+3)'(1);
        w_pr   = (CW+3)'(pal_rd_q[3*CW-1 -: CW]) * w_bmul;
        w_pg   = (CW+3)'(pal_rd_q[2*CW-1 -: CW]) * w_bmul;
        w_pb   = (CW+3)'(pal_rd_q[CW-1:0])       * w_bmul;
    end

    always_comb begin
        addr_d   = addr_q;
        blank1_d = blank1_q;
        blank2_d = blank2_q;
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;
        if (cen) begin
            addr_d   = {w_sel, w_col};
            blank1_d = ~HB_n | ~VB_n;
            blank2_d = blank1_q;
            if (blank2_q) begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
            end else begin
                red_d   = w_pr[CW+2:3];
                green_d = w_pg[CW+2:3];
                blue_d  = w_pb[CW+2:3];
            end
        end
    end

    // Requests may arrive on non-cen clocks; they are held pending until
    // the next cen so the FSM itself only moves on pixel boundaries.
    always_comb begin
        w_req_out = pend_out_q | fade_out;
        w_req_in  = (pend_in_q | fade_in) & ~w_req_out;
        w_tick    = vb_hist_q & ~VB_n;
        w_step    = w_tick && (fcnt_q == c_FLAST);

        state_d    = state_q;
        bright_d   = bright_q;
        fcnt_d     = fcnt_q;
        vb_hist_d  = vb_hist_q;
        pend_out_d = w_req_out;
        pend_in_d  = pend_in_q | fade_in;

        if (cen) begin
            pend_out_d = 1'b0;
            pend_in_d  = 1'b0;
            vb_hist_d  = VB_n;
            case (state_q)
                c_ST_IDLE: begin
                    bright_d = 3'd7;
                    if (w_req_out) begin
                        state_d = c_ST_OUT;
                        fcnt_d  = 4'd0;
                    end
                end
                c_ST_OUT: begin
                    if (w_req_in) begin
                        state_d = c_ST_IN;
                        fcnt_d  = 4'd0;
                    end else if (w_step) begin
                        fcnt_d   = 4'd0;
                        bright_d = bright_q - 3'd1;
                        if (bright_q == 3'd1)
                            state_d = c_ST_BLACK;
                    end else if (w_tick) begin
                        fcnt_d = fcnt_q + 4'd1;
                    end
                end
                c_ST_BLACK: begin
                    bright_d = 3'd0;
                    if (w_req_in) begin
                        state_d = c_ST_IN;
                        fcnt_d  = 4'd0;
                    end
                end
                c_ST_IN: begin
                    if (w_req_out) begin
                        state_d = c_ST_OUT;
                        fcnt_d  = 4'd0;
                    end else if (w_step) begin
                        fcnt_d   = 4'd0;
                        bright_d = bright_q + 3'd1;
                        if (bright_q == 3'd6)
                            state_d = c_ST_IDLE;
                    end else if (w_tick) begin
                        fcnt_d = fcnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d  = c_ST_IDLE;
                    bright_d = 3'd7;
                    fcnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            blank1_q   <= 1'b1;
            blank2_q   <= 1'b1;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            state_q    <= c_ST_IDLE;
            bright_q   <= 3'd7;
            fcnt_q     <= 4'd0;
            vb_hist_q  <= 1'b1;
            pend_out_q <= 1'b0;
            pend_in_q  <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            blank1_q   <= blank1_d;
            blank2_q   <= blank2_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            state_q    <= state_d;
            bright_q   <= bright_d;
            fcnt_q     <= fcnt_d;
            vb_hist_q  <= vb_hist_d;
            pend_out_q <= pend_out_d;
            pend_in_q  <= pend_in_d;
        end
    end

    assign fade_busy = (state_q == c_ST_OUT) | (state_q == c_ST_IN);
    assign red       = red_q;
    assign green     = green_q;
    assign blue      = blue_q;

endmodule
`default_nettype wire

// File: tb/tb_jtpopeye_colmix_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtpopeye_colmix_n
// Purpose  : Directed self-checking bench for jtpopeye_colmix_n (NL=3, IW=5,
//            CW=3, FSTEP=2): priority/palette, latency, blanking, cen hold,
//            fade ramps, reversal, request collision, RAM collision, reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtpopeye_colmix_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic [6:0]  prog_addr = '0;
    logic [8:0]  prog_din = '0;
    logic        prog_we = 1'b0;
    logic [14:0] lay_col = '0;
    logic [2:0]  lay_v = '0;
    logic        HB_n = 1'b1;
    logic        VB_n = 1'b1;
    logic        fade_out = 1'b0;
    logic        fade_in = 1'b0;
    logic        fade_busy;
    logic [2:0]  red, green, blue;

    int n_tests = 0;
    int n_fail  = 0;

    jtpopeye_colmix_n #(.NL(3), .IW(5), .CW(3), .FSTEP(2)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .prog_addr(prog_addr), .prog_din(prog_din), .prog_we(prog_we),
        .lay_col(lay_col), .lay_v(lay_v),
        .HB_n(HB_n), .VB_n(VB_n),
        .fade_out(fade_out), .fade_in(fade_in), .fade_busy(fade_busy),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pal_write(input logic [6:0] a, input logic [8:0] d);
        prog_addr = a;
        prog_din  = d;
        prog_we   = 1'b1;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic set_pix(input logic [2:0] v, input logic [4:0] i0,
                           input logic [4:0] i1, input logic [4:0] i2);
        lay_v   = v;
        lay_col = {i2, i1, i0};
    endtask

    // One VB_n fall, then enough pixels for an unblanked output to emerge.
    task automatic frame_tick();
        VB_n = 1'b0;
        step();
        VB_n = 1'b1;
        step();
        step();
        step();
    endtask

    task automatic pulse_out();
        fade_out = 1'b1;
        step();
        fade_out = 1'b0;
    endtask

    task automatic pulse_in();
        fade_in = 1'b1;
        step();
        fade_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_tests++;
        if ({red, green, blue} !== 9'o000) begin
            n_fail++;
            $display("FAIL reset_rgb: got %o want %o", {red, green, blue}, 9'o000);
        end
        n_tests++;
        if (fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", fade_busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_priority();
        pal_write({2'd2, 5'd3}, 9'o777);
        pal_write({2'd0, 5'd1}, 9'o124);
        pal_write({2'd1, 5'd7}, 9'o351);
        // background only
        set_pix(3'b000, 5'd1, 5'd7, 5'd3);
        step(); step(); step();
        n_tests++;
        if ({red, green, blue} !== 9'o777) begin
            n_fail++;
            $display("FAIL prio_bg: got %o want %o", {red, green, blue}, 9'o777);
        end
        // layer 0 opaque; output must not change before the third edge
        set_pix(3'b001, 5'd1, 5'd7, 5'd3);
        step(); step();
        n_tests++;
        if ({red, green, blue} !== 9'o777) begin
            n_fail++;
            $display("FAIL latency_early: got %o want %o", {red, green, blue}, 9'o777);
        end
        step();
        n_tests++;
        if ({red, green, blue} !== 9'o124) begin
            n_fail++;
            $display("FAIL prio_l0: got %o want %o", {red, green, blue}, 9'o124);
        end
        set_pix(3'b110, 5'd1, 5'd7, 5'd3);
        step(); step(); step();
        n_tests++;
        if ({red, green, blue} !== 9'o351) begin
            n_fail++;
            $display("FAIL prio_l1: got %o want %o", {red, green, blue}, 9'o351);
        end
        set_pix(3'b011, 5'd1, 5'd7, 5'd3);
        step(); step(); step();
        n_tests++;
        if ({red, green, blue} !== 9'o124) begin
            n_fail++;
            $display("FAIL prio_l0_over_l1: got %o want %o", {red, green, blue}, 9'o124);
        end
        set_pix(3'b100, 5'd1, 5'd7, 5'd3);
        step(); step(); step();
        n_tests++;
        if ({red, green, blue} !== 9'o777) begin
            n_fail++;
            $display("FAIL prio_bgflag_ignored: got %o want %o", {red, green, blue}, 9'o777);
        end
    endtask

    task automatic test_blank();
        set_pix(3'b000, 5'd1, 5'd7, 5'd3);
        step(); step(); step();
        HB_n = 1'b0;
        step();
        HB_n = 1'b1;
        step();
        n_tests++;
        if ({red, green, blue} !== 9'o777) begin
            n_fail++;
            $display("FAIL blank_before: got %o want %o", {red, green, blue}, 9'o777);
        end
        step();
        n_tests++;
        if ({red, green, blue} !== 9'o000) begin
            n_fail++;
            $display("FAIL blank_pixel: got %o want %o", {red, green, blue}, 9'o000);
        end
        step();
        n_tests++;
        if ({red, green, blue} !== 9'o777) begin
            n_fail++;
            $display("FAIL blank_after: got %o want %o", {red, green, blue}, 9'o777);
        end
    endtask

    task automatic test_cen_hold();
        cen = 1'b0;
        set_pix(3'b001, 5'd2, 5'd7, 5'd3);
        pal_write({2'd0, 5'd2}, 9'o246);
        HB_n = 1'b0;
        step(); step(); step(); step();
        n_tests++;
        if ({red, green, blue} !== 9'o777) begin
            n_fail++;
            $display("FAIL cen_hold: got %o want %o", {red, green, blue}, 9'o777);
        end
        HB_n = 1'b1;
        cen = 1'b1;
        step(); step(); step();
        n_tests++;
        if ({red, green, blue} !== 9'o246) begin
            n_fail++;
            $display("FAIL cen_write: got %o want %o", {red, green, blue}, 9'o246);
        end
    endtask

    task automatic test_pal_collision();
        set_pix(3'b001, 5'd1, 5'd7, 5'd3);
        step(); step(); step();
        prog_addr = {2'd0, 5'd1};
        prog_din  = 9'o365;
        prog_we   = 1'b1;
        step();
        prog_we   = 1'b0;
        step();
        n_tests++;
        if ({red, green, blue} !== 9'o124) begin
            n_fail++;
            $display("FAIL ram_collide_old: got %o want %o", {red, green, blue}, 9'o124);
        end
        step();
        n_tests++;
        if ({red, green, blue} !== 9'o365) begin
            n_fail++;
            $display("FAIL ram_collide_new: got %o want %o", {red, green, blue}, 9'o365);
        end
    endtask

    task automatic test_fade_ramp();
        set_pix(3'b000, 5'd1, 5'd7, 5'd3);
        step(); step(); step();
        pulse_out();
        n_tests++;
        if (fade_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fade_out_busy: got %b want 1", fade_busy);
        end
        for (int i = 1; i <= 14; i++) begin
            frame_tick();
            n_tests++;
            if (red !== 3'(7 - i / 2)) begin
                n_fail++;
                $display("FAIL fade_out_tick%0d: got %0d want %0d", i, red, 7 - i / 2);
            end
        end
        n_tests++;
        if (fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL black_busy: got %b want 0", fade_busy);
        end
    endtask

    task automatic test_reversal();
        pulse_in();
        n_tests++;
        if (fade_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fade_in_busy: got %b want 1", fade_busy);
        end
        for (int i = 1; i <= 14; i++) begin
            frame_tick();
            n_tests++;
            if (red !== 3'(i / 2)) begin
                n_fail++;
                $display("FAIL fade_in_tick%0d: got %0d want %0d", i, red, i / 2);
            end
        end
        n_tests++;
        if (fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fade_in_idle: got %b want 0", fade_busy);
        end
        pulse_out();
        for (int i = 0; i < 4; i++) frame_tick();
        n_tests++;
        if (red !== 3'd5) begin
            n_fail++;
            $display("FAIL rev_mid: got %0d want 5", red);
        end
        pulse_in();
        n_tests++;
        if (fade_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rev_busy: got %b want 1", fade_busy);
        end
        for (int i = 0; i < 4; i++) frame_tick();
        n_tests++;
        if (red !== 3'd7 || fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rev_end: got red=%0d busy=%b want red=7 busy=0", red, fade_busy);
        end
    endtask

    task automatic test_req_collision();
        fade_out = 1'b1;
        fade_in  = 1'b1;
        step();
        fade_out = 1'b0;
        fade_in  = 1'b0;
        n_tests++;
        if (fade_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL both_busy: got %b want 1", fade_busy);
        end
        frame_tick();
        frame_tick();
        n_tests++;
        if (red !== 3'd6) begin
            n_fail++;
            $display("FAIL both_out_wins: got %0d want 6", red);
        end
        pulse_in();
        frame_tick();
        frame_tick();
        n_tests++;
        if (red !== 3'd7 || fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL both_recover: got red=%0d busy=%b want red=7 busy=0", red, fade_busy);
        end
    endtask

    task automatic test_reset_mid_fade();
        pulse_out();
        for (int i = 0; i < 8; i++) frame_tick();
        n_tests++;
        if (red !== 3'd3 || fade_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midfade_pre: got red=%0d busy=%b want red=3 busy=1", red, fade_busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if ({red, green, blue} !== 9'o000 || fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midfade_rst: got rgb=%o busy=%b want rgb=000 busy=0",
                     {red, green, blue}, fade_busy);
        end
        step(); step(); step();
        n_tests++;
        if ({red, green, blue} !== 9'o777) begin
            n_fail++;
            $display("FAIL midfade_full: got %o want %o", {red, green, blue}, 9'o777);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_blank();
        test_cen_hold();
        test_pal_collision();
        test_fade_ramp();
        test_reversal();
        test_req_collision();
        test_reset_mid_fade();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
